// File: rtl/imem_line_responder_if.sv
// Backing-memory read bus between the line responder and the slow single-word memory.
interface imem_line_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/imem_line_responder.sv
// Dual-word instruction responder: direct-mapped line buffer in front of a slow
// handshaked backing memory. Returns words at A and A+4 combinationally on a hit,
// otherwise stalls fetch and fills the missing line(s) one word at a time.
module imem_line_responder #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_W-1:0]     Instr_address_2IM,
    input  logic                  flush,
    output logic [31:0]           Instr1_fIM,
    output logic [31:0]           Instr2_fIM,
    output logic                  imem_stall,
    imem_line_responder_if.master mem
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W - 2;
    localparam logic [OFF_W-1:0] K_LAST = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
    logic              fill_start;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [OFF_W-1:0]  off_a, off_b;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic [TAG_W-1:0]  tag_a, tag_b;
    logic              hit_a, hit_b, hit;

    // B wraps modulo 2^ADDR_W, so the top word's partner is word 0
    assign addr_a = Instr_address_2IM;
    assign addr_b = Instr_address_2IM + ADDR_W'(4);
    assign off_a  = addr_a[OFF_W+1:2];
    assign off_b  = addr_b[OFF_W+1:2];
    assign idx_a  = addr_a[OFF_W+2 +: IDX_W];
    assign idx_b  = addr_b[OFF_W+2 +: IDX_W];
    assign tag_a  = addr_a[ADDR_W-1 -: TAG_W];
    assign tag_b  = addr_b[ADDR_W-1 -: TAG_W];

    assign hit_a = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
    assign hit_b = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
    assign hit   = hit_a && hit_b;

    assign mem.mem_req  = (state_q == FILL);
    assign mem.mem_addr = addr_q;

    // Fetch-side outputs: data only on a full dual hit, stall whenever busy or missing
    always_comb begin
        Instr1_fIM = '0;
        Instr2_fIM = '0;
        if (hit) begin
            Instr1_fIM = data_q[idx_a][off_a];
            Instr2_fIM = data_q[idx_b][off_b];
        end
        imem_stall = !hit || (state_q != IDLE);
    end

    // Fill FSM next-state: pick the missing line (A first), walk its words, then publish
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        addr_d     = addr_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        fill_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit && !flush) begin
                    fill_start = 1'b1;
                    state_d    = FILL;
                    k_d        = '0;
                    if (!hit_a) begin
                        fill_idx_d = idx_a;
                        fill_tag_d = tag_a;
                        addr_d     = {tag_a, idx_a, {(OFF_W+2){1'b0}}};
                    end else begin
                        fill_idx_d = idx_b;
                        fill_tag_d = tag_b;
                        addr_d     = {tag_b, idx_b, {(OFF_W+2){1'b0}}};
                    end
                end
            end
            FILL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem.mem_ack) begin
                    if (k_q == K_LAST) begin
                        state_d = DONE;
                    end else begin
                        k_d    = k_q + 1'b1;
                        addr_d = addr_q + ADDR_W'(4);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and fill-bookkeeping registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            k_q        <= '0;
            addr_q     <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
        end
    end

    // Valid bits: flush overrides everything, including a fill completing this edge
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill_start) begin
            valid_q[fill_idx_d] <= 1'b0;
        end else if (state_q == DONE) begin
            valid_q[fill_idx_q] <= 1'b1;
        end
    end

    // Tag and data storage, deliberately not reset; valid gates their use
    always_ff @(posedge CLK) begin
        if (state_q == FILL && mem.mem_ack) begin
            data_q[fill_idx_q][k_q] <= mem.mem_rdata;
        end
        if (state_q == DONE) begin
            tag_q[fill_idx_q] <= fill_tag_q;
        end
    end
endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: a backing memory whose contents are a
// fixed function of the address, a per-cycle checker that any unstalled output
// equals that memory, and directed checks on fill address sequences and timing.
module tb_imem_line_responder;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] A = 32'h0040_0000;
    logic        flush = 1'b0;
    logic [31:0] i1, i2;
    logic        stall;
    logic        cmp_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ackq [$];

    imem_line_responder_if #(.ADDR_W(32)) mbus ();

    imem_line_responder #(
        .LINE_WORDS (4),
        .NUM_LINES  (16),
        .ADDR_W     (32)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Instr_address_2IM (A),
        .flush             (flush),
        .Instr1_fIM        (i1),
        .Instr2_fIM        (i2),
        .imem_stall        (stall),
        .mem               (mbus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ({a[31:2], 2'b00} ^ 32'h5A5A_0000) + 32'h0000_1111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing memory: acks each request two cycles after it is seen, drops on withdrawal
    initial begin
        int dly;
        dly = 0;
        mbus.mem_ack   = 1'b0;
        mbus.mem_rdata = '0;
        forever begin
            @(negedge CLK);
            if (!mbus.mem_req || mbus.mem_ack) begin
                mbus.mem_ack = 1'b0;
                dly = 0;
            end else if (dly == 1) begin
                mbus.mem_ack   = 1'b1;
                mbus.mem_rdata = memf(mbus.mem_addr);
            end else begin
                dly++;
            end
        end
    end

    // Record every word address the memory actually delivered
    always @(posedge CLK) begin
        if (RESET && mbus.mem_req && mbus.mem_ack) ackq.push_back(mbus.mem_addr);
    end

    // Every cycle: unstalled output must equal backing memory, stalled output must be zero
    always @(negedge CLK) begin
        if (RESET && cmp_en) begin
            if (!stall) begin
                chk("cyc_instr1", i1, memf(A));
                chk("cyc_instr2", i2, memf(A + 32'd4));
                chk("cyc_req_on_hit", 32'(mbus.mem_req), 32'd0);
            end else begin
                chk("cyc_instr1_stall", i1, 32'd0);
                chk("cyc_instr2_stall", i2, 32'd0);
            end
        end
    end

    task automatic wait_acks(input int n, input string name);
        for (int c = 0; c < 200 && ackq.size() < n; c++) begin
            @(posedge CLK); #1;
        end
        chk(name, 32'(ackq.size() >= n), 32'd1);
    endtask

    task automatic wait_hit(input string name);
        for (int c = 0; c < 300 && stall; c++) begin
            @(posedge CLK); #1;
        end
        chk(name, 32'(stall), 32'd0);
    endtask

    task automatic expect_words(input logic [31:0] base, input int n, input string name);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = (ackq.size() > 0) ? ackq.pop_front() : 32'hDEAD_BEEF;
            chk(name, a, base + 32'(4 * k));
        end
    endtask

    task automatic expect_empty(input string name);
        chk(name, 32'(ackq.size()), 32'd0);
    endtask

    task automatic set_addr(input logic [31:0] a);
        @(posedge CLK); #1;
        A = a;
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_req", 32'(mbus.mem_req), 32'd0);
        chk("rst_addr", mbus.mem_addr, 32'd0);
        chk("rst_instr1", i1, 32'd0);
        @(posedge CLK); #3;
        RESET  = 1'b1;
        cmp_en = 1'b1;

        // cold start: 4 words, stall through DONE, hit the cycle after
        wait_acks(4, "cold_acks_timeout");
        chk("cold_done_stall", 32'(stall), 32'd1);
        @(posedge CLK); #1;
        chk("cold_hit_stall", 32'(stall), 32'd0);
        chk("cold_instr1", i1, 32'h5A1A_1111);
        chk("cold_instr2", i2, 32'h5A1A_1115);
        expect_words(32'h0040_0000, 4, "cold_fill_addr");
        expect_empty("cold_no_extra");

        // cross-line: only the next line is fetched
        set_addr(32'h0040_000C);
        wait_hit("cross_timeout");
        chk("cross_instr1", i1, 32'h5A1A_111D);
        chk("cross_instr2", i2, 32'h5A1A_1121);
        expect_words(32'h0040_0010, 4, "cross_fill_addr");
        expect_empty("cross_no_extra");
        set_addr(32'h0040_0008);
        chk("rehit_stall", 32'(stall), 32'd0);
        chk("rehit_req", 32'(mbus.mem_req), 32'd0);
        @(posedge CLK); #1;
        chk("rehit_req_next", 32'(mbus.mem_req), 32'd0);
        expect_empty("rehit_no_fill");

        // conflict eviction on index 0
        set_addr(32'h0040_0100);
        wait_hit("conf1_timeout");
        chk("conf1_instr1", i1, 32'h5A1A_1211);
        expect_words(32'h0040_0100, 4, "conf1_fill_addr");
        set_addr(32'h0040_0000);
        wait_hit("conf2_timeout");
        chk("conf2_instr1", i1, 32'h5A1A_1111);
        expect_words(32'h0040_0000, 4, "conf2_fill_addr");
        expect_empty("conf_no_extra");

        // flush after the 2nd ack aborts the fill and restarts from the line base
        set_addr(32'h0040_0020);
        wait_acks(2, "flush_acks_timeout");
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        chk("flush_req_drop", 32'(mbus.mem_req), 32'd0);
        chk("flush_stall", 32'(stall), 32'd1);
        expect_words(32'h0040_0020, 2, "flush_partial_addr");
        wait_hit("flush_refill_timeout");
        expect_words(32'h0040_0020, 4, "flush_refill_addr");
        expect_empty("flush_no_extra");
        set_addr(32'h0040_0000);
        chk("flush_cleared_miss", 32'(stall), 32'd1);
        wait_hit("postflush_timeout");
        expect_words(32'h0040_0000, 4, "postflush_fill_addr");

        // async reset mid-fill
        set_addr(32'h0040_0030);
        wait_acks(1, "rst_acks_timeout");
        @(posedge CLK); #3;
        RESET = 1'b0;
        #1;
        chk("midrst_req", 32'(mbus.mem_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd1);
        chk("midrst_instr1", i1, 32'd0);
        ackq.delete();
        @(posedge CLK); #3;
        RESET = 1'b1;
        wait_hit("midrst_refill_timeout");
        expect_words(32'h0040_0030, 4, "midrst_fill_addr");
        expect_empty("midrst_no_extra");

        // address wrap: two fills, top line then line 0
        set_addr(32'hFFFF_FFFC);
        wait_hit("wrap_timeout");
        expect_words(32'hFFFF_FFF0, 4, "wrap_fill_top");
        expect_words(32'h0000_0000, 4, "wrap_fill_zero");
        expect_empty("wrap_no_extra");
        chk("wrap_instr1", i1, 32'hA5A6_110D);
        chk("wrap_instr2", i2, 32'h5A5A_1111);

        @(posedge CLK); #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
